// File: rtl/vga_axil_regs.sv
// AXI-Lite register bank for the VGA control plane: byte-strobed writes with
// independent AW/W hold slots, one-cycle read latency, SLVERR on illegal access.
module vga_axil_regs #(
    parameter int                  NUM_REGS = 8,
    parameter int                  ADDR_W   = 8,
    parameter int                  DATA_W   = 32,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic [ADDR_W-1:0]            awaddr,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W/8-1:0]          wstrb,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [ADDR_W-1:0]            araddr,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [DATA_W-1:0]            rdata,
    output logic [1:0]                   rresp,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_i,
    output logic [NUM_REGS-1:0]          wr_pulse_o
);
    localparam int         IDX_W       = ADDR_W - 2;
    localparam int         NB          = DATA_W / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    if (DATA_W != 32) begin : g_bad_data_w
        $error("vga_axil_regs: DATA_W must be 32");
    end
    if ((1 << IDX_W) < NUM_REGS) begin : g_bad_addr_w
        $error("vga_axil_regs: ADDR_W too small for NUM_REGS");
    end

    function automatic logic is_writable(input logic [IDX_W-1:0] idx);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            if (idx == IDX_W'(i) && !RO_MASK[i]) ok = 1'b1;
        return ok;
    endfunction

    logic                run_q;
    logic                aw_held_q, w_held_q;
    logic [IDX_W-1:0]    aw_idx_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [NB-1:0]       w_strb_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic                aw_hs, w_hs, write_fire, w_legal;
    logic [IDX_W-1:0]    w_idx, ar_idx;
    logic [DATA_W-1:0]   w_data_c, rd_data_c;
    logic [NB-1:0]       w_strb_c;
    logic [1:0]          rd_resp_c;
    logic                unused_bits;

    assign unused_bits = ^{awaddr[1:0], araddr[1:0]};

    // A held beat counts as available; an empty slot means ready is high, so
    // the live valid alone decides the handshake.
    assign write_fire = run_q && (aw_held_q || awvalid) && (w_held_q || wvalid)
                        && (!bvalid || bready);
    assign awready    = run_q && (!aw_held_q || write_fire);
    assign wready     = run_q && (!w_held_q || write_fire);
    assign aw_hs      = awvalid && awready;
    assign w_hs       = wvalid && wready;

    assign w_idx    = aw_held_q ? aw_idx_q : awaddr[ADDR_W-1:2];
    assign w_data_c = w_held_q ? w_data_q : wdata;
    assign w_strb_c = w_held_q ? w_strb_q : wstrb;
    assign w_legal  = is_writable(w_idx);

    always_ff @(posedge clk) begin
        if (aw_hs) aw_idx_q <= awaddr[ADDR_W-1:2];
        if (w_hs) begin
            w_data_q <= wdata;
            w_strb_q <= wstrb;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            run_q      <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            bvalid     <= 1'b0;
            bresp      <= RESP_OKAY;
            wr_pulse_o <= '0;
        end else begin
            run_q     <= 1'b1;
            aw_held_q <= aw_held_q ? (!write_fire || aw_hs) : (aw_hs && !write_fire);
            w_held_q  <= w_held_q  ? (!write_fire || w_hs)  : (w_hs && !write_fire);
            for (int i = 0; i < NUM_REGS; i++)
                wr_pulse_o[i] <= write_fire && w_legal && (|w_strb_c) && (w_idx == IDX_W'(i));
            if (write_fire) begin
                bvalid <= 1'b1;
                bresp  <= w_legal ? RESP_OKAY : RESP_SLVERR;
            end else if (bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (write_fire && w_legal) begin
            for (int i = 0; i < NUM_REGS; i++)
                for (int k = 0; k < NB; k++)
                    if (w_idx == IDX_W'(i) && w_strb_c[k])
                        regs_q[i][k*8 +: 8] <= w_data_c[k*8 +: 8];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
        assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign arready = run_q && (!rvalid || rready);
    assign ar_idx  = araddr[ADDR_W-1:2];

    always_comb begin
        rd_data_c = '0;
        rd_resp_c = RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                rd_resp_c = RESP_OKAY;
                rd_data_c = RO_MASK[i] ? hw_i[i*DATA_W +: DATA_W] : regs_q[i];
            end
        end
    end

    // Read response registered; holds while the master stalls rready.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (arvalid && arready) begin
            rvalid <= 1'b1;
            rdata  <= rd_data_c;
            rresp  <= rd_resp_c;
        end else if (rready) begin
            rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_axil_regs.sv
// Bench for vga_axil_regs: directed and random AXI-Lite traffic checked
// against a simple array model of the register file.
module tb_vga_axil_regs;
    localparam int            NR = 8;
    localparam logic [NR-1:0] RO = 8'h04;

    logic             clk = 1'b0, arst_n = 1'b1;
    logic [7:0]       awaddr = '0, araddr = '0;
    logic             awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic             awready, wready, bvalid, arready, rvalid;
    logic [31:0]      wdata = '0, rdata;
    logic [3:0]       wstrb = '0;
    logic [1:0]       bresp, rresp;
    logic [NR*32-1:0] regs_o, hw_i;
    logic [NR-1:0]    wr_pulse_o;

    always #5 clk = ~clk;

    vga_axil_regs #(.NUM_REGS(NR), .ADDR_W(8), .DATA_W(32), .RO_MASK(RO)) dut (
        .clk(clk), .arst_n(arst_n),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .regs_o(regs_o), .hw_i(hw_i), .wr_pulse_o(wr_pulse_o)
    );

    int          n_chk = 0, n_fail = 0;
    logic [31:0] mdl [NR];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] exp_vec();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*32 +: 32] = mdl[i];
        return v;
    endfunction

    // Reference behaviour: apply a write to the model, return response and pulse.
    task automatic mdl_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [NR-1:0] pulse);
        int idx;
        idx   = int'(a >> 2);
        pulse = '0;
        if (idx < NR && !RO[idx]) begin
            resp = 2'b00;
            for (int k = 0; k < 4; k++) if (s[k]) mdl[idx][k*8 +: 8] = d[k*8 +: 8];
            if (s != 4'h0) pulse[idx] = 1'b1;
        end else begin
            resp = 2'b10;
        end
    endtask

    task automatic mdl_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        int idx;
        idx = int'(a >> 2);
        if (idx >= NR) begin
            d = 32'h0; resp = 2'b10;
        end else begin
            d = RO[idx] ? hw_i[idx*32 +: 32] : mdl[idx];
            resp = 2'b00;
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int t;
        logic [1:0] er;
        logic [NR-1:0] ep;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        t = 0;
        while (!(awready && wready) && t < 16) begin @(negedge clk); t++; end
        chk("wr_ready", {awready, wready}, 2'b11);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        mdl_write(a, d, s, er, ep);
        chk("wr_bvalid", bvalid, 1'b1);
        chk("wr_bresp", bresp, er);
        chk("wr_pulse", wr_pulse_o, ep);
        chk("wr_regs", regs_o, exp_vec());
        @(negedge clk);
        chk("wr_bvalid_clr", bvalid, 1'b0);
        chk("wr_pulse_clr", wr_pulse_o, '0);
    endtask

    task automatic do_read(input logic [7:0] a);
        int t;
        logic [31:0] ed;
        logic [1:0] er;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        t = 0;
        while (!arready && t < 16) begin @(negedge clk); t++; end
        chk("rd_ready", arready, 1'b1);
        mdl_read(a, ed, er);
        @(negedge clk);
        arvalid = 1'b0;
        chk("rd_rvalid", rvalid, 1'b1);
        chk("rd_rdata", rdata, ed);
        chk("rd_rresp", rresp, er);
        @(negedge clk);
        chk("rd_rvalid_clr", rvalid, 1'b0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_arready", arready, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rresp", rresp, 2'b00);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_pulse", wr_pulse_o, '0);
        chk("rst_regs", regs_o, '0);
    endtask

    initial begin
        logic [31:0]   bd [NR];
        logic [1:0]    br [NR];
        logic [NR-1:0] bp [NR];
        logic [31:0]   ed, old;
        logic [1:0]    er;
        logic [NR-1:0] ep;
        logic [7:0]    a;

        for (int i = 0; i < NR; i++) begin
            mdl[i] = '0;
            hw_i[i*32 +: 32] = $urandom;
        end
        hw_i[2*32 +: 32] = 32'h12345678;

        #1 arst_n = 1'b0;
        #1 chk_reset_outputs();
        @(negedge clk) arst_n = 1'b1;
        @(negedge clk);

        // Byte-strobe merge
        do_write(8'h04, 32'hDEADBEEF, 4'hF);
        do_write(8'h04, 32'h00005500, 4'b0010);
        chk("merge_reg1", regs_o[32 +: 32], 32'hDEAD55EF);
        do_write(8'h0C, 32'hFFFFFFFF, 4'h0);

        // Read-only and out-of-range
        do_write(8'h08, 32'hA5A5A5A5, 4'hF);
        do_read(8'h08);
        chk("ro_value", rdata, 32'h12345678);
        do_write(8'h20, 32'h11111111, 4'hF);
        do_read(8'h20);

        // W three cycles before AW, B stalled, then AW before W
        bready = 1'b0;
        wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
        chk("st_wready0", wready, 1'b1);
        @(negedge clk) wvalid = 1'b0;
        chk("st_wready_held", wready, 1'b0);
        @(negedge clk); @(negedge clk);
        awaddr = 8'h14; awvalid = 1'b1;
        chk("st_awready0", awready, 1'b1);
        @(negedge clk) awvalid = 1'b0;
        mdl_write(8'h14, 32'h0BADF00D, 4'hF, er, ep);
        chk("st_pulse5", wr_pulse_o, ep);
        chk("st_regs5", regs_o, exp_vec());
        awaddr = 8'h18; awvalid = 1'b1;
        @(negedge clk) awvalid = 1'b0;
        wdata = 32'h600DCAFE; wvalid = 1'b1;
        chk("st_wready1", wready, 1'b1);
        @(negedge clk) wvalid = 1'b0;
        awaddr = 8'h1C; awvalid = 1'b1; wdata = 32'hFFFF0000; wvalid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk("st_bvalid_hold", bvalid, 1'b1);
            chk("st_bresp_hold", bresp, 2'b00);
            chk("st_awready_full", awready, 1'b0);
            chk("st_wready_full", wready, 1'b0);
            chk("st_regs_hold", regs_o, exp_vec());
            @(negedge clk);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        @(negedge clk);
        mdl_write(8'h18, 32'h600DCAFE, 4'hF, er, ep);
        chk("st_bvalid_reload", bvalid, 1'b1);
        chk("st_pulse6", wr_pulse_o, ep);
        chk("st_regs6", regs_o, exp_vec());
        @(negedge clk);
        chk("st_bvalid_done", bvalid, 1'b0);
        chk("st_no_extra", regs_o, exp_vec());

        // Back-to-back writes, one per cycle
        bready = 1'b1;
        for (int i = 0; i <= NR; i++) begin
            if (i > 0) begin
                chk("bb_bvalid", bvalid, 1'b1);
                chk("bb_bresp", bresp, br[i-1]);
                chk("bb_pulse", wr_pulse_o, bp[i-1]);
            end
            if (i < NR) begin
                bd[i] = $urandom;
                awaddr = 8'(i * 4); wdata = bd[i]; wstrb = 4'hF;
                awvalid = 1'b1; wvalid = 1'b1;
                chk("bb_ready", {awready, wready}, 2'b11);
                mdl_write(8'(i * 4), bd[i], 4'hF, br[i], bp[i]);
            end else begin
                awvalid = 1'b0; wvalid = 1'b0;
            end
            @(negedge clk);
        end
        chk("bb_bvalid_end", bvalid, 1'b0);
        chk("bb_regs", regs_o, exp_vec());

        // Back-to-back reads, one per cycle
        rready = 1'b1;
        for (int i = 0; i <= NR; i++) begin
            if (i > 0) begin
                chk("rb_rvalid", rvalid, 1'b1);
                chk("rb_rdata", rdata, bd[i-1]);
                chk("rb_rresp", rresp, br[i-1]);
            end
            if (i < NR) begin
                araddr = 8'(i * 4); arvalid = 1'b1;
                mdl_read(8'(i * 4), bd[i], br[i]);
                chk("rb_arready", arready, 1'b1);
            end else begin
                arvalid = 1'b0;
            end
            @(negedge clk);
        end
        chk("rb_rvalid_end", rvalid, 1'b0);

        // Read and write to the same register in one cycle
        old = mdl[3];
        awaddr = 8'h0C; wdata = 32'h13572468; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h0C; arvalid = 1'b1;
        chk("rw_ready", {awready, wready, arready}, 3'b111);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        mdl_write(8'h0C, 32'h13572468, 4'hF, er, ep);
        chk("rw_old_data", rdata, old);
        chk("rw_regs", regs_o, exp_vec());
        @(negedge clk);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom_range(0, 11) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom_range(0, 15)));
            else do_read(a);
        end

        // Reset with AW held and W pending
        do_read(8'h04);
        awaddr = 8'h04; awvalid = 1'b1; bready = 1'b1;
        @(negedge clk) awvalid = 1'b0;
        wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1;
        #2 arst_n = 1'b0;
        #1 chk_reset_outputs();
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        wvalid = 1'b0;
        @(negedge clk) arst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_regs", regs_o, '0);
        do_write(8'h04, 32'hCAFEF00D, 4'hF);
        do_read(8'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
